fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 167 ++++++++++++++++
 tb/tb_fb_scanout.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: streams a 1-bpp framebuffer out of memory as a pixel stream.
// Requests walk the frame word by word, responses land in a 2-entry FIFO,
// and the head word is shifted out one pixel per handshake, LSB first.
module fb_scanout #(
  parameter int unsigned FB_WIDTH  = 64,
  parameter int unsigned FB_HEIGHT = 64,
  parameter logic [31:0] FB_BASE   = 32'h0000_2000,
  localparam int unsigned XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1,
  localparam int unsigned YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_req_valid,
  input  logic          rd_req_ready,
  output logic [31:0]   rd_req_addr,
  input  logic          rd_resp_valid,
  input  logic [31:0]   rd_resp_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eol
);

  localparam int unsigned   NREQ     = FB_WIDTH * FB_HEIGHT / 32;
  localparam int unsigned   RW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [RW-1:0] LAST_REQ = RW'(NREQ - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] req_idx_q, req_idx_d;
  logic [1:0]    out_q, out_d;
  logic [31:0]   fifo_q [2];
  logic [31:0]   fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          done_q, done_d;

  logic          req_fire;
  logic          resp_acc;
  logic          pix_fire;
  logic          pop;
  logic          last_req;
  logic          last_pix;
  logic [31:0]   head;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (req_fire && last_req) state_d = DRAIN;
      DRAIN:   if (last_pix) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; the request gate counts FIFO words plus requests in flight,
  // which never exceeds the two FIFO slots
  always_comb begin
    busy         = (state_q != IDLE);
    done         = done_q;
    rd_req_valid = (state_q == SCAN) && ((3'(cnt_q) + 3'(out_q)) < 3'd2);
    rd_req_addr  = FB_BASE + (32'(req_idx_q) << 2);
    head         = fifo_q[rd_ptr_q];
    pix_valid    = (cnt_q != '0);
    pix_data     = pix_valid & head[x_q[4:0]];
    pix_x        = x_q;
    pix_y        = y_q;
    pix_sof      = pix_valid && (x_q == '0) && (y_q == '0);
    pix_eol      = pix_valid && (x_q == X_LAST);
  end

  // Request/response bookkeeping, FIFO and pixel counters
  always_comb begin
    req_fire  = rd_req_valid && rd_req_ready;
    resp_acc  = rd_resp_valid && (out_q != '0);
    pix_fire  = pix_valid && pix_ready;
    pop       = pix_fire && (x_q[4:0] == 5'd31);
    last_req  = (req_idx_q == LAST_REQ);
    last_pix  = pix_fire && (x_q == X_LAST) && (y_q == Y_LAST);

    req_idx_d = req_idx_q;
    if (req_fire) begin
      req_idx_d = last_req ? '0 : req_idx_q + RW'(1);
    end

    out_d    = out_q + 2'(req_fire) - 2'(resp_acc);

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (resp_acc) begin
      fifo_d[wr_ptr_q] = rd_resp_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + 2'(resp_acc) - 2'(pop);

    x_d = x_q;
    y_d = y_q;
    if (pix_fire) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    done_d = last_pix && (state_q == DRAIN);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_idx_q <= '0;
      out_q     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      req_idx_q <= req_idx_d;
      out_q     <= out_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: frame scenarios from a table, memory responder with
// configurable latency, and a pixel scoreboard built from the memory image.
module tb_fb_scanout;

  localparam int unsigned W    = 64;
  localparam int unsigned H    = 64;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int unsigned NREQ = W * H / 32;
  localparam int unsigned NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic        rd_resp_valid;
  logic [31:0] rd_resp_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic [5:0]  pix_x;
  logic [5:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;

  fb_scanout #(
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .FB_BASE  (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic [5:0] x;
    logic [5:0] y;
    logic       sof;
    logic       eol;
  } pix_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    int          pat;        // 0: single word set, 1: random image
    int unsigned word_idx;
    logic [31:0] word_val;
    int unsigned ready_pct;
    int unsigned lat;
    bit          rreq_rand;
    int          mid_start;  // pixel count at which start is re-pulsed, -1 none
    int          exp_ones;   // -1: take from model
    int unsigned exp_x;
    int unsigned exp_y;
    bit          chk_rate;
  } scen_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  logic [31:0] mem     [NREQ];
  logic [31:0] rnd_mem [NREQ];
  pix_t        exp_q [$];
  resp_t       pend  [$];

  bit          eng_on;
  int unsigned ready_pct, lat;
  bit          rreq_rand;
  int unsigned hs_count, eol_cnt, sof_cnt, ones_cnt, done_cnt, req_k, resp_cnt;
  int unsigned first_hs_cyc, last_hs_cyc, model_ones;
  logic [5:0]  one_x, one_y;
  bit          last_hs_prev, first_resp_prev, req_stall_prev;

  scen_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // One cycle: sample outputs at negedge, then choose inputs for the next posedge
  task automatic step();
    pix_t  got;
    pix_t  ep;
    resp_t r;
    @(negedge clk);
    cyc++;
    if (!eng_on) return;

    chk("done_pulse", 64'(done), 64'(last_hs_prev));
    last_hs_prev = 1'b0;
    if (done) done_cnt++;
    if (first_resp_prev) begin
      chk("first_pix_latency", 64'(pix_valid), 64'd1);
      first_resp_prev = 1'b0;
    end

    pix_ready = ($urandom_range(99, 0) < ready_pct);
    if (pix_valid) begin
      if (exp_q.size() == 0) begin
        flag("extra_pixel");
      end else begin
        got = {pix_data, pix_x, pix_y, pix_sof, pix_eol};
        chk("pixel", 64'(got), 64'(exp_q[0]));
        if (pix_ready) begin
          ep = exp_q.pop_front();
          if (hs_count == 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          hs_count++;
          if (pix_eol) eol_cnt++;
          if (pix_sof) sof_cnt++;
          if (pix_data) begin
            ones_cnt++;
            one_x = pix_x;
            one_y = pix_y;
          end
          if (exp_q.size() == 0 && hs_count == NPIX) last_hs_prev = 1'b1;
        end
      end
    end

    rd_resp_valid = 1'b0;
    rd_resp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      rd_resp_valid = 1'b1;
      rd_resp_data  = r.data;
      if (resp_cnt == 0) first_resp_prev = 1'b1;
      resp_cnt++;
    end

    if (req_stall_prev) chk("req_valid_hold", 64'(rd_req_valid), 64'd1);
    rd_req_ready = rreq_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    req_stall_prev = rd_req_valid && !rd_req_ready;
    if (rd_req_valid && rd_req_ready) begin
      chk("req_addr", 64'(rd_req_addr), 64'(BASE + 32'(req_k * 4)));
      if (req_k >= NREQ) begin
        flag("extra_request");
      end else begin
        r.due  = cyc + 1 + lat;
        r.data = mem[req_k];
        pend.push_back(r);
      end
      req_k++;
      chk("outstanding_le_2", 64'(pend.size() <= 2), 64'd1);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      64'(busy),         64'd0);
    chk({tag, "_done"},      64'(done),         64'd0);
    chk({tag, "_req_valid"}, 64'(rd_req_valid), 64'd0);
    chk({tag, "_req_addr"},  64'(rd_req_addr),  64'(BASE));
    chk({tag, "_pix_valid"}, 64'(pix_valid),    64'd0);
    chk({tag, "_pix_data"},  64'(pix_data),     64'd0);
    chk({tag, "_pix_sof"},   64'(pix_sof),      64'd0);
    chk({tag, "_pix_eol"},   64'(pix_eol),      64'd0);
    chk({tag, "_pix_x"},     64'(pix_x),        64'd0);
    chk({tag, "_pix_y"},     64'(pix_y),        64'd0);
  endtask

  task automatic prep_frame(input scen_t s);
    pix_t p;
    for (int unsigned i = 0; i < NREQ; i++) mem[i] = (s.pat == 1) ? rnd_mem[i] : 32'h0;
    if (s.pat == 0) mem[s.word_idx] = s.word_val;
    exp_q.delete();
    pend.delete();
    model_ones = 0;
    for (int unsigned y = 0; y < H; y++) begin
      for (int unsigned x = 0; x < W; x++) begin
        p.d   = mem[y * (W / 32) + x / 32][x % 32];
        p.x   = 6'(x);
        p.y   = 6'(y);
        p.sof = (x == 0) && (y == 0);
        p.eol = (x == W - 1);
        if (p.d) model_ones++;
        exp_q.push_back(p);
      end
    end
    ready_pct = s.ready_pct;
    lat       = s.lat;
    rreq_rand = s.rreq_rand;
    hs_count = 0; eol_cnt = 0; sof_cnt = 0; ones_cnt = 0; done_cnt = 0;
    req_k = 0; resp_cnt = 0; first_hs_cyc = 0; last_hs_cyc = 0;
    one_x = '0; one_y = '0;
    last_hs_prev = 1'b0; first_resp_prev = 1'b0; req_stall_prev = 1'b0;
    eng_on = 1'b1;
  endtask

  task automatic launch();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("req_valid_latency", 64'(rd_req_valid), 64'd1);
  endtask

  task automatic run_frame(input scen_t s, input string tag);
    int unsigned guard;
    bit          pulsed;
    prep_frame(s);
    launch();
    guard  = 0;
    pulsed = 1'b0;
    while (done_cnt == 0 && guard < 25000) begin
      step();
      guard++;
      if (s.mid_start >= 0 && !pulsed && hs_count >= s.mid_start) begin
        start = 1'b1;
        step();
        start = 1'b0;
        pulsed = 1'b1;
      end
    end
    chk({tag, "_frame_in_time"}, 64'(guard < 25000), 64'd1);
    repeat (8) step();
    chk({tag, "_pixels"},    64'(hs_count),     64'(NPIX));
    chk({tag, "_left"},      64'(exp_q.size()), 64'd0);
    chk({tag, "_eol_count"}, 64'(eol_cnt),      64'(H));
    chk({tag, "_sof_count"}, 64'(sof_cnt),      64'd1);
    chk({tag, "_done_count"},64'(done_cnt),     64'd1);
    chk({tag, "_requests"},  64'(req_k),        64'(NREQ));
    chk({tag, "_ones"},      64'(ones_cnt),     64'((s.exp_ones >= 0) ? s.exp_ones : model_ones));
    if (s.exp_ones == 1) begin
      chk({tag, "_one_x"}, 64'(one_x), 64'(s.exp_x));
      chk({tag, "_one_y"}, 64'(one_y), 64'(s.exp_y));
    end
    if (s.chk_rate) chk({tag, "_rate"}, 64'(last_hs_cyc - first_hs_cyc), 64'(NPIX - 1));
    chk({tag, "_idle_busy"},  64'(busy),         64'd0);
    chk({tag, "_idle_req"},   64'(rd_req_valid), 64'd0);
    chk({tag, "_idle_pix"},   64'(pix_valid),    64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned guard;

    tbl[0] = '{pat:0, word_idx:0,   word_val:32'h0000_0001, ready_pct:100, lat:0,  rreq_rand:0, mid_start:-1,  exp_ones:1,  exp_x:0,  exp_y:0,  chk_rate:1};
    tbl[1] = '{pat:0, word_idx:67,  word_val:32'h0000_0001, ready_pct:100, lat:0,  rreq_rand:0, mid_start:-1,  exp_ones:1,  exp_x:32, exp_y:33, chk_rate:1};
    tbl[2] = '{pat:0, word_idx:0,   word_val:32'h0000_0001, ready_pct:50,  lat:0,  rreq_rand:0, mid_start:-1,  exp_ones:1,  exp_x:0,  exp_y:0,  chk_rate:0};
    tbl[3] = '{pat:1, word_idx:0,   word_val:32'h0,         ready_pct:100, lat:0,  rreq_rand:1, mid_start:-1,  exp_ones:-1, exp_x:0,  exp_y:0,  chk_rate:0};
    tbl[4] = '{pat:1, word_idx:0,   word_val:32'h0,         ready_pct:100, lat:20, rreq_rand:1, mid_start:-1,  exp_ones:-1, exp_x:0,  exp_y:0,  chk_rate:0};
    tbl[5] = '{pat:0, word_idx:0,   word_val:32'h0000_0001, ready_pct:100, lat:0,  rreq_rand:0, mid_start:500, exp_ones:1,  exp_x:0,  exp_y:0,  chk_rate:0};
    tbl[6] = '{pat:1, word_idx:0,   word_val:32'h0,         ready_pct:50,  lat:20, rreq_rand:1, mid_start:-1,  exp_ones:-1, exp_x:0,  exp_y:0,  chk_rate:0};
    tbl[7] = '{pat:0, word_idx:127, word_val:32'h8000_0000, ready_pct:100, lat:20, rreq_rand:0, mid_start:-1,  exp_ones:1,  exp_x:63, exp_y:63, chk_rate:0};

    for (int unsigned i = 0; i < NREQ; i++) rnd_mem[i] = $urandom();

    eng_on        = 1'b0;
    rst           = 1'b1;
    start         = 1'b0;
    rd_req_ready  = 1'b0;
    rd_resp_valid = 1'b0;
    rd_resp_data  = '0;
    pix_ready     = 1'b0;
    repeat (3) step();
    chk_reset("por");
    rst = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      run_frame(tbl[i], $sformatf("scen%0d", i));
    end

    // Abort a frame with reset, then inject a stale response
    prep_frame(tbl[3]);
    launch();
    guard = 0;
    while (hs_count < 1000 && guard < 10000) begin
      step();
      guard++;
    end
    chk("abort_reached_1000", 64'(hs_count >= 1000), 64'd1);
    step();
    eng_on        = 1'b0;
    rd_req_ready  = 1'b0;
    rd_resp_valid = 1'b0;
    pix_ready     = 1'b0;
    rst           = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("midrst");
    step();
    step();
    rd_resp_valid = 1'b1;
    rd_resp_data  = 32'hFFFF_FFFF;
    step();
    rd_resp_valid = 1'b0;
    rd_resp_data  = '0;
    repeat (5) begin
      step();
      chk("stale_pix_valid", 64'(pix_valid),    64'd0);
      chk("stale_req_valid", 64'(rd_req_valid), 64'd0);
      chk("stale_busy",      64'(busy),         64'd0);
      chk("stale_done",      64'(done),         64'd0);
    end
    run_frame(tbl[0], "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
